// File: rtl/sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_prog
// Description : Single-clock parametrised FIFO with occupancy count,
//               runtime-programmable almost-full/almost-empty thresholds,
//               synchronous flush and sticky overflow/underflow flags.
//               Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads;
//               without it, reads are registered with one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_prog #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEPTH      = 256,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  half_full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_half  = c_depth >> 1;
    localparam logic [ADDR_WIDTH:0] c_one   = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_full;
    logic                  r_half_full;
    logic                  r_almost_full;
    logic                  r_empty;
    logic                  r_almost_empty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [ADDR_WIDTH:0]   w_mem_cnt;
    logic                  w_mem_avail;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_pop_mem;
    logic                  w_rd_valid_next;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic                  w_full_next;
    logic                  w_half_next;
    logic                  w_af_next;
    logic                  w_empty_next;
    logic                  w_ae_next;

    // Words currently held in the storage array (excludes a presented FWFT word)
    assign w_mem_cnt   = r_wr_ptr - r_rd_ptr;
    assign w_mem_avail = (w_mem_cnt != '0);

    // Full is taken from the current cycle, so a same-cycle read never frees room
    assign w_wr_acc = wr_en & ~r_full & ~flush;

`ifdef SYNC_FIFO_FWFT_EN
    // A pop consumes the presented word; the array refills the output slot
    // whenever it is vacant or being vacated this cycle.
    assign w_rd_acc  = rd_en & r_rd_valid & ~flush;
    assign w_pop_mem = w_mem_avail & (~r_rd_valid | w_rd_acc) & ~flush;

    // Presented-word valid: refill sets it, an unrefilled pop clears it
    always_comb begin
        w_rd_valid_next = r_rd_valid;
        if (flush) begin
            w_rd_valid_next = 1'b0;
        end else if (w_pop_mem) begin
            w_rd_valid_next = 1'b1;
        end else if (w_rd_acc) begin
            w_rd_valid_next = 1'b0;
        end
    end
`else
    // Registered read: the array pointer advances on every accepted read.
    // The count and the pointer gap always agree; the gap term keeps the
    // pointer pair self-consistent.
    assign w_rd_acc        = rd_en & ~r_empty & w_mem_avail & ~flush;
    assign w_pop_mem       = w_rd_acc;
    assign w_rd_valid_next = w_rd_acc;
`endif

    // Next occupancy and the status flags derived from it
    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   w_count_next = r_count + c_one;
                2'b01:   w_count_next = r_count - c_one;
                default: w_count_next = r_count;
            endcase
        end

        w_full_next  = (w_count_next == c_depth);
        w_half_next  = (w_count_next >= c_half);
        w_af_next    = (w_count_next >= af_thresh);
        w_ae_next    = (w_count_next <= ae_thresh);
`ifdef SYNC_FIFO_FWFT_EN
        w_empty_next = ~w_rd_valid_next;
`else
        w_empty_next = (w_count_next == '0);
`endif

        // A flush leaves the flags exactly as reset does, whatever the thresholds
        if (flush) begin
            w_full_next  = 1'b0;
            w_half_next  = 1'b0;
            w_af_next    = 1'b0;
            w_ae_next    = 1'b1;
            w_empty_next = 1'b1;
        end
    end

    // Storage array write; contents are deliberately left untouched by reset/flush
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Pointers, occupancy, read port and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_rd_data      <= '0;
            r_rd_valid     <= 1'b0;
            r_full         <= 1'b0;
            r_half_full    <= 1'b0;
            r_almost_full  <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= r_wr_ptr + c_one;
                end
                if (w_pop_mem) begin
                    r_rd_ptr <= r_rd_ptr + c_one;
                end
            end
            // rd_data holds its last value (also across a flush) unless reloaded
            if (w_pop_mem) begin
                r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
            end
            r_rd_valid     <= w_rd_valid_next;
            r_count        <= w_count_next;
            r_full         <= w_full_next;
            r_half_full    <= w_half_next;
            r_almost_full  <= w_af_next;
            r_empty        <= w_empty_next;
            r_almost_empty <= w_ae_next;
        end
    end

    // Sticky error flags: a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (wr_en & r_full  & ~flush) | (r_overflow  & ~clr_err);
            r_underflow <= (rd_en & r_empty & ~flush) | (r_underflow & ~clr_err);
        end
    end

    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign count        = r_count;
    assign full         = r_full;
    assign half_full    = r_half_full;
    assign almost_full  = r_almost_full;
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_prog
// Description : Self-checking bench for sync_fifo_prog (DEPTH=16, 8-bit).
//               Stimulus pushes expected read words into a scoreboard queue;
//               a negedge monitor pops and compares whenever a word is
//               presented. Status outputs are compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_prog;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          flush = 1'b0;
    logic          clr_err = 1'b0;
    logic [AW:0]   af_thresh = 5'd14;
    logic [AW:0]   ae_thresh = 5'd2;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          full, half_full, almost_full, empty, almost_empty;
    logic          overflow, underflow;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] sb[$];
    logic [DW-1:0] mq[$];
    int            mcount = 0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .flush(flush), .clr_err(clr_err), .af_thresh(af_thresh),
        .ae_thresh(ae_thresh), .count(count), .full(full),
        .half_full(half_full), .almost_full(almost_full), .empty(empty),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents/consumes a word
    always @(negedge clk) begin
        if (rst_n) begin
`ifdef SYNC_FIFO_FWFT_EN
            if (rd_valid && rd_en) begin
`else
            if (rd_valid) begin
`endif
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL rd_data unexpected: got 0x%0h with empty scoreboard at %0t", rd_data, $time);
                end else begin
                    automatic logic [DW-1:0] exp = sb.pop_front();
                    if (rd_data !== exp) begin
                        failures++;
                        $display("FAIL rd_data: got 0x%0h expected 0x%0h at %0t", rd_data, exp, $time);
                    end
                end
            end
        end
    end

    // Status check against the bench's reference occupancy/error model
    task automatic check_status(input logic exp_rv, input logic was_flush);
        chk("count", 32'(count), 32'(mcount));
        chk("full", 32'(full), 32'(mcount == DEPTH));
        chk("empty", 32'(empty), 32'(mcount == 0));
        chk("half_full", 32'(half_full), 32'(!was_flush && mcount >= DEPTH / 2));
        chk("almost_full", 32'(almost_full), 32'(!was_flush && mcount >= int'(af_thresh)));
        chk("almost_empty", 32'(almost_empty), 32'(was_flush || mcount <= int'(ae_thresh)));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("rd_valid", 32'(rd_valid), 32'(exp_rv));
    endtask

    // One clock of standard-mode stimulus with model update and status check
    task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re,
                         input logic fl, input logic ce);
        logic mfull, mempty, wacc, racc;
        mfull  = (mcount == DEPTH);
        mempty = (mcount == 0);
        wr_en = we; wr_data = wd; rd_en = re; flush = fl; clr_err = ce;
        m_ovf = (we & mfull & ~fl) | (m_ovf & ~ce);
        m_unf = (re & mempty & ~fl) | (m_unf & ~ce);
        wacc  = we & ~mfull & ~fl;
        racc  = re & ~mempty & ~fl;
        if (fl) begin
            mq.delete();
            mcount = 0;
        end else begin
            if (racc) sb.push_back(mq.pop_front());
            if (wacc) mq.push_back(wd);
            mcount = mcount + int'(wacc) - int'(racc);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        check_status(racc, fl);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(posedge clk); #1;
        chk("reset count", 32'(count), 32'd0);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset almost_empty", 32'(almost_empty), 32'd1);
        chk("reset full", 32'(full), 32'd0);
        chk("reset rd_data", 32'(rd_data), 32'd0);
        chk("reset rd_valid", 32'(rd_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifndef SYNC_FIFO_FWFT_EN
        // Fill completely with 0x01..0x10
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        chk("filled count", 32'(count), 32'd16);
        chk("filled full", 32'(full), 32'd1);

        // Rejected write while full, sticky overflow, then clear
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("overflow sticky", 32'(overflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("overflow cleared", 32'(overflow), 32'd0);

        // Drain in order, then an underflowing read
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("underflow set", 32'(underflow), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Fill to 8, then 40 cycles of simultaneous read/write across the wrap
        for (int i = 0; i < 8; i++) cycle(1'b1, DW'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, DW'(8'h40 + i), 1'b1, 1'b0, 1'b0);
        chk("steady count", 32'(count), 32'd8);

        // Down to 5, flush with a competing write, then a 0x5A round trip
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("pre-flush count", 32'(count), 32'd5);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        chk("flush count", 32'(count), 32'd0);
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Runtime threshold changes, including the forcing extremes
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h70 + i), 1'b0, 1'b0, 1'b0);
        af_thresh = 5'd3;  ae_thresh = 5'd2;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        af_thresh = 5'd4;  ae_thresh = 5'd3;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        af_thresh = 5'd0;  ae_thresh = 5'd16;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("af forced", 32'(almost_full), 32'd1);
        chk("ae forced", 32'(almost_empty), 32'd1);
        af_thresh = 5'd14; ae_thresh = 5'd2;
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-operation, no clock edge needed
        #2 rst_n = 1'b0;
        #1;
        chk("async reset count", 32'(count), 32'd0);
        chk("async reset empty", 32'(empty), 32'd1);
        mq.delete(); mcount = 0; m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`else
        // Single word falls through without a request
        wr_en = 1'b1; wr_data = 8'h3C; sb.push_back(8'h3C);
        @(posedge clk); #1;
        wr_en = 1'b0;
        chk("fwft rd_valid after write edge", 32'(rd_valid), 32'd0);
        @(posedge clk); #1;
        chk("fwft rd_valid", 32'(rd_valid), 32'd1);
        chk("fwft rd_data", 32'(rd_data), 32'h3C);
        chk("fwft count", 32'(count), 32'd1);
        chk("fwft empty", 32'(empty), 32'd0);
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        chk("fwft pop rd_valid", 32'(rd_valid), 32'd0);
        chk("fwft pop empty", 32'(empty), 32'd1);
        chk("fwft pop count", 32'(count), 32'd0);

        // Two words, popped back to back
        wr_en = 1'b1; wr_data = 8'hB0; sb.push_back(8'hB0);
        @(posedge clk); #1;
        wr_data = 8'hB1; sb.push_back(8'hB1);
        @(posedge clk); #1;
        wr_en = 1'b0;
        chk("fwft head", 32'(rd_data), 32'hB0);
        chk("fwft count2", 32'(count), 32'd2);
        rd_en = 1'b1;
        @(posedge clk); #1;
        chk("fwft next head valid", 32'(rd_valid), 32'd1);
        chk("fwft next head", 32'(rd_data), 32'hB1);
        @(posedge clk); #1;
        rd_en = 1'b0;
        chk("fwft drained", 32'(rd_valid), 32'd0);
        chk("fwft drained count", 32'(count), 32'd0);
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        chk("fwft underflow", 32'(underflow), 32'd1);
`endif
        @(posedge clk); #1;
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
